mmram_match_ctrl: RTL
=====================

Name: mmram_match_ctrl

Overview:
- Sequencing controller in front of the matching-memory stage.
- Accepts tokens from the upstream stage and classifies each as one of: pass-through, first operand, second operand or collision.
- Drives the stage's WR_E, DEL and ADDR together with the held packet.
- Keeps a 64-entry occupancy/key table that mirrors the stage RAM, so waiting operands are tracked, paired and released without RAM read-back.

Parameters:
- AW, 6, address width; table depth is 2**AW.
- KEYW, 18, width of the color_gen_dest key, PKT[37:20].
- PW, 38, packet width.

Ports:
- CP  in  1  clock; all state updates on the rising edge.
- MR  in  1  master reset, asynchronous, active-high.
- PKT_VALID  in  1  upstream token valid.
- PKT_IN  in  38  token: [37:27] color/gen, [26:20] dest, [19] LR, [18] MF, [17:16] C/Z, [15:0] data.
- PKT_READY  out  1  token accepted when PKT_VALID&PKT_READY at CP edge.
- ISSUE_VALID  out  1  command to the matching stage is valid.
- ISSUE_ACK  in  1  stage accepted command (one-cycle pulse).
- ISSUE_PKT  out  38  held token for the stage PACKET_IN.
- WR_E  out  1  write the RAM entry.
- DEL  out  1  absorb the token (no downstream send).
- ADDR  out  6  RAM/table index.
- FLUSH  in  1  request to clear all occupancy.
- OCC_COUNT  out  7  number of occupied entries, 0..64.
- COLLISION  out  1  one-cycle pulse per stall cycle caused by a key mismatch.
- ERR  out  1  sticky protocol error.

Behaviour:
- Reset, MR=1, asynchronous:
  - State IDLE.
  - PKT_READY=0, ISSUE_VALID=0, WR_E=0, DEL=0, ADDR=0, ISSUE_PKT=0, OCC_COUNT=0, COLLISION=0, ERR=0.
  - All occupancy bits cleared. Key/LR table contents are don't-care.
- Hash: ADDR = PKT[25:20] ^ PKT[32:27], i.e. dest[5:0] XOR color[5:0]. Key = PKT[37:20].
- State IDLE:
  - PKT_READY=1 unless FLUSH is pending.
  - On accept: latch the token into the hold register and go to LOOKUP.
- State LOOKUP, one cycle, PKT_READY=0, classification against the table at ADDR:
  - MF=0: pass-through. WR_E=0, DEL=0, ADDR=hash. Table unchanged.
  - MF=1, entry empty: first operand. WR_E=1, DEL=1.
  - MF=1, occupied, key equal, LR differs from stored LR: second operand. WR_E=0, DEL=0.
  - MF=1, occupied, key equal, LR same as stored LR: set ERR=1 and treat the token as second operand.
  - MF=1, occupied, key differs: go to STALL.
  - All non-STALL outcomes go to ISSUE.
- State STALL:
  - COLLISION=1 every cycle in this state.
  - Re-evaluate the entry each cycle. Leave for ISSUE as soon as the entry is empty or the key matches.
  - The token is never dropped.
- State ISSUE:
  - ISSUE_VALID=1. ISSUE_PKT, WR_E, DEL and ADDR are held stable until ISSUE_ACK.
  - On ISSUE_ACK, table update:
    - First operand: set occupancy, store key and LR, OCC_COUNT+1.
    - Second operand: clear occupancy, OCC_COUNT-1.
    - Pass-through: no change.
  - Then go to IDLE, with ISSUE_VALID, WR_E and DEL dropped to 0 in the same edge.
  - ISSUE_ACK outside ISSUE is ignored.
- FLUSH:
  - Sampled every cycle and stored as pending.
  - Executed only in IDLE with no token accepted in that cycle: all occupancy bits clear and OCC_COUNT=0 in one cycle, then pending is cleared.
  - A token in flight completes first.
  - ERR is not cleared by FLUSH, only by MR.
- OCC_COUNT:
  - Never exceeds 64 or goes below 0. An update that would do so sets ERR and holds the count.
  - A table update and a flush never coincide.
- Latency and throughput:
  - Accept to ISSUE_VALID = 2 CP edges with no stall.
  - Minimum 3 cycles per token: IDLE, LOOKUP, ISSUE with immediate ack.
- MR mid-operation: the held token is discarded, outputs go to reset values immediately, and the table is emptied.

Test Plan:
- Reset, then token MF=0, dest=5, color=0, data=0x1234 → ISSUE_VALID on edge 2 with WR_E=0, DEL=0, ISSUE_PKT equal to input; OCC_COUNT stays 0.
- Token MF=1, LR=0, dest=10, color=3, then partner LR=1 with the same key:
  - First token: ADDR=9, WR_E=1, DEL=1, OCC_COUNT becomes 1 after ack.
  - Second token: ADDR=9, WR_E=0, DEL=0, OCC_COUNT returns to 0.
- Collision, MF=1 throughout:
  - Occupy addr 9 with dest=10, color=3; then send dest=9, color=0 (also hash 9).
  - Second token: STALL, COLLISION=1 each cycle, PKT_READY=0.
  - Release with the partner of the first token: the stalled token then issues as first operand, WR_E=1.
- Hold ISSUE_ACK low for 5 cycles with a first-operand token → ISSUE_VALID/WR_E/ADDR stable for 5 cycles; table updates only on the ack edge.
- Two first operands same key, same LR=0 → ERR=1 sticky; second issued with WR_E=0; ERR survives FLUSH and is cleared only by MR.
- Occupy 3 entries, assert FLUSH during ISSUE → flush deferred until IDLE, then OCC_COUNT=0. Assert MR during LOOKUP → all outputs 0 asynchronously and the table is empty afterwards.

Source files
------------

// File: rtl/mmram_match_ctrl_if.sv
// Bus bundle between the matching-memory sequencing controller and its
// surroundings (upstream token source, matching stage and flush control).
//
//   PKT_VALID / PKT_IN / PKT_READY : upstream token handshake
//   ISSUE_VALID / ISSUE_ACK        : command handshake towards the stage
//   ISSUE_PKT / WR_E / DEL / ADDR  : command payload held for the stage
//   FLUSH                          : request to clear the occupancy table
//   OCC_COUNT / COLLISION / ERR    : status
//
// modport master : environment side (drives tokens, acks and flush)
// modport slave  : controller side
interface mmram_match_ctrl_if #(
    parameter int AW = 6,
    parameter int PW = 38
);
    logic          PKT_VALID;
    logic [PW-1:0] PKT_IN;
    logic          PKT_READY;
    logic          ISSUE_VALID;
    logic          ISSUE_ACK;
    logic [PW-1:0] ISSUE_PKT;
    logic          WR_E;
    logic          DEL;
    logic [AW-1:0] ADDR;
    logic          FLUSH;
    logic [AW:0]   OCC_COUNT;
    logic          COLLISION;
    logic          ERR;

    modport master (
        output PKT_VALID, PKT_IN, ISSUE_ACK, FLUSH,
        input  PKT_READY, ISSUE_VALID, ISSUE_PKT, WR_E, DEL, ADDR,
               OCC_COUNT, COLLISION, ERR
    );

    modport slave (
        input  PKT_VALID, PKT_IN, ISSUE_ACK, FLUSH,
        output PKT_READY, ISSUE_VALID, ISSUE_PKT, WR_E, DEL, ADDR,
               OCC_COUNT, COLLISION, ERR
    );
endinterface

// File: rtl/mmram_match_ctrl.sv
// Sequencing controller in front of the matching-memory stage.
// Each accepted token is classified against a local occupancy/key table
// (a mirror of the stage RAM) as pass-through, first operand, second operand
// or collision, and a command (WR_E/DEL/ADDR plus the held token) is issued
// to the stage. The table is updated only when the stage acknowledges.
//
// Ports:
//   CP  : clock, rising edge
//   MR  : master reset, asynchronous, active-high
//   bus : mmram_match_ctrl_if.slave (token in, command out, flush, status)
//
// While a token is stalled on a key mismatch, the only token allowed in is
// the partner of the blocking entry (same key, opposite LR). It is swapped
// in ahead of the stalled token, which is parked and re-looked-up once the
// partner has been issued; this is what frees a stalled entry.
module mmram_match_ctrl #(
    parameter int AW   = 6,
    parameter int KEYW = 18,
    parameter int PW   = 38
) (
    input  logic             CP,
    input  logic             MR,
    mmram_match_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_STALL, ST_ISSUE} state_t;
    typedef enum logic [2:0] {CL_PASS, CL_FIRST, CL_SECOND, CL_DUP, CL_STALL} cls_t;

    // Table index: low dest bits XOR low color bits.
    function automatic logic [AW-1:0] hash_f(input logic [PW-1:0] p);
        return p[20 +: AW] ^ p[27 +: AW];
    endfunction

    // Match key: color/gen and dest.
    function automatic logic [KEYW-1:0] key_f(input logic [PW-1:0] p);
        return p[PW-1 -: KEYW];
    endfunction

    // Classify a token against one table entry.
    function automatic cls_t classify_f(input logic [PW-1:0] p, input logic occ,
                                        input logic [KEYW-1:0] key, input logic lr);
        cls_t c;
        if (!p[18]) begin
            c = CL_PASS;
        end else if (!occ) begin
            c = CL_FIRST;
        end else if (key_f(p) == key) begin
            if (p[19] != lr) begin
                c = CL_SECOND;
            end else begin
                c = CL_DUP;
            end
        end else begin
            c = CL_STALL;
        end
        return c;
    endfunction

    state_t          state_r, state_s;
    cls_t            cls_r, cls_s;
    logic [PW-1:0]   hold_r, park_r;
    logic            park_vld_r;
    logic [AW-1:0]   addr_r;
    logic            pkt_ready_r, issue_valid_r, wr_e_r, del_r, collision_r, err_r;
    logic [AW:0]     occ_cnt_r;
    logic            flush_pend_r;
    logic [DEPTH-1:0] occ_r;
    logic [KEYW-1:0] key_mem_r [DEPTH];
    logic [DEPTH-1:0] lr_mem_r;

    logic accept_s, ack_s, partner_s, do_flush_s, flush_pend_s, ready_s, enter_issue_s;

    assign accept_s  = bus.PKT_VALID & pkt_ready_r;
    assign ack_s     = (state_r == ST_ISSUE) & bus.ISSUE_ACK;
    assign cls_s     = classify_f(hold_r, occ_r[addr_r], key_mem_r[addr_r], lr_mem_r[addr_r]);
    // A presented token that would free the entry the held token is blocked on.
    assign partner_s = bus.PKT_VALID & bus.PKT_IN[18] & occ_r[addr_r]
                     & (key_f(bus.PKT_IN) == key_mem_r[addr_r])
                     & (bus.PKT_IN[19] != lr_mem_r[addr_r]);
    assign do_flush_s    = (state_r == ST_IDLE) & flush_pend_r & ~accept_s;
    assign flush_pend_s  = (flush_pend_r & ~do_flush_s) | bus.FLUSH;
    assign ready_s       = ((state_s == ST_IDLE) & ~flush_pend_s)
                         | ((state_s == ST_STALL) & partner_s);
    assign enter_issue_s = (state_s == ST_ISSUE) & (state_r != ST_ISSUE);

    // State register.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_LOOKUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (cls_s == CL_STALL) begin
                    state_s = ST_STALL;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_STALL: begin
                if (accept_s) begin
                    state_s = ST_LOOKUP;
                end else if (cls_s != CL_STALL) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_STALL;
                end
            end
            ST_ISSUE: begin
                if (ack_s) begin
                    if (park_vld_r) begin
                        state_s = ST_LOOKUP;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Token hold/park registers, registered outputs, occupancy and count.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            hold_r        <= '0;
            park_r        <= '0;
            park_vld_r    <= 1'b0;
            addr_r        <= '0;
            cls_r         <= CL_PASS;
            pkt_ready_r   <= 1'b0;
            issue_valid_r <= 1'b0;
            wr_e_r        <= 1'b0;
            del_r         <= 1'b0;
            collision_r   <= 1'b0;
            err_r         <= 1'b0;
            occ_cnt_r     <= '0;
            flush_pend_r  <= 1'b0;
            occ_r         <= '0;
        end else begin
            flush_pend_r  <= flush_pend_s;
            pkt_ready_r   <= ready_s;
            issue_valid_r <= (state_s == ST_ISSUE);
            collision_r   <= (state_s == ST_STALL);

            if (accept_s && state_r == ST_STALL) begin
                park_r     <= hold_r;
                park_vld_r <= 1'b1;
                hold_r     <= bus.PKT_IN;
                addr_r     <= hash_f(bus.PKT_IN);
            end else if (accept_s) begin
                hold_r <= bus.PKT_IN;
                addr_r <= hash_f(bus.PKT_IN);
            end else if (ack_s && park_vld_r) begin
                hold_r     <= park_r;
                addr_r     <= hash_f(park_r);
                park_vld_r <= 1'b0;
            end

            if (enter_issue_s) begin
                cls_r  <= cls_s;
                wr_e_r <= (cls_s == CL_FIRST);
                del_r  <= (cls_s == CL_FIRST);
                if (cls_s == CL_DUP) begin
                    err_r <= 1'b1;
                end
            end else if (ack_s) begin
                wr_e_r <= 1'b0;
                del_r  <= 1'b0;
            end

            if (do_flush_s) begin
                occ_r     <= '0;
                occ_cnt_r <= '0;
            end else if (ack_s) begin
                case (cls_r)
                    CL_FIRST: begin
                        occ_r[addr_r] <= 1'b1;
                        if (occ_cnt_r == CNT_MAX) begin
                            err_r <= 1'b1;
                        end else begin
                            occ_cnt_r <= occ_cnt_r + (AW + 1)'(1);
                        end
                    end
                    CL_SECOND, CL_DUP: begin
                        occ_r[addr_r] <= 1'b0;
                        if (occ_cnt_r == '0) begin
                            err_r <= 1'b1;
                        end else begin
                            occ_cnt_r <= occ_cnt_r - (AW + 1)'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Key/LR store for first operands; contents only meaningful where occupied.
    always_ff @(posedge CP) begin
        if (ack_s && cls_r == CL_FIRST) begin
            key_mem_r[addr_r] <= key_f(hold_r);
            lr_mem_r[addr_r]  <= hold_r[19];
        end
    end

    assign bus.PKT_READY   = pkt_ready_r;
    assign bus.ISSUE_VALID = issue_valid_r;
    assign bus.ISSUE_PKT   = hold_r;
    assign bus.WR_E        = wr_e_r;
    assign bus.DEL         = del_r;
    assign bus.ADDR        = addr_r;
    assign bus.OCC_COUNT   = occ_cnt_r;
    assign bus.COLLISION   = collision_r;
    assign bus.ERR         = err_r;
endmodule
